// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter.
// Provides the bus widths and the arbiter state encoding.
package mem_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_LOCK  = 2'd2
    } state_t;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Round-robin pick: combinational priority search over a request vector,
// starting at ptr and wrapping modulo N.
// Ports:
//   req   - request vector, one bit per requester
//   ptr   - index with highest priority this cycle
//   idx   - first requesting index at or after ptr (wrapping); ptr if none
//   found - at least one request is present
module mem_arbiter_rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    int cand;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        idx   = ptr;
        cand  = 0;
        found = |req;
        for (int k = N - 1; k >= 0; k--) begin
            cand = (int'(ptr) + k) % N;
            if (req[cand]) begin
                idx = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Memory arbiter: shares one RAM port between N_PORTS cache ports.
// Round-robin arbitration with one IDLE bubble between grants; a lock mode
// holds the grant on one port for atomic read-modify-write sequences.
// The cache handshake is passed through: a request completes when the
// granted port's request is high and mem_wait is low at a rising edge.
// Ports:
//   clk, clr_n            - clock, synchronous active-low reset
//   c_addr, c_data_w      - per-port address / write data, 32 bits per port
//   c_read, c_write       - per-port request strobes
//   c_atomic              - per-port lock request
//   c_wait                - per-port stall
//   c_data_r              - read data broadcast (equals mem_data_r)
//   mem_*                 - memory side of the shared port
//   gnt                   - current grant index
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int N_PORTS = 4,
    parameter int IDX_W   = 2
) (
    input  logic                      clk,
    input  logic                      clr_n,
    input  logic [ADDR_W*N_PORTS-1:0] c_addr,
    input  logic [DATA_W*N_PORTS-1:0] c_data_w,
    input  logic [N_PORTS-1:0]        c_read,
    input  logic [N_PORTS-1:0]        c_write,
    input  logic [N_PORTS-1:0]        c_atomic,
    output logic [N_PORTS-1:0]        c_wait,
    output logic [DATA_W-1:0]         c_data_r,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_data_w,
    output logic                      mem_read,
    output logic                      mem_write,
    output logic                      mem_atomic,
    input  logic                      mem_wait,
    input  logic [DATA_W-1:0]         mem_data_r,
    output logic [IDX_W-1:0]          gnt
);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic [N_PORTS-1:0] req;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_found;
    logic               g_req;
    logic               g_atomic;
    logic               done;
    logic [IDX_W-1:0]   next_ptr;

    assign req      = c_read | c_write;
    assign g_req    = req[gnt_q];
    assign g_atomic = c_atomic[gnt_q];
    assign done     = g_req & ~mem_wait;
    assign next_ptr = (int'(gnt_q) == N_PORTS - 1) ? '0 : gnt_q + 1'b1;
    assign gnt      = gnt_q;
    assign c_data_r = mem_data_r;

    mem_arbiter_rr_pick #(
        .N     (N_PORTS),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req   (req),
        .ptr   (rr_ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    gnt_d   = pick_idx;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // A withdrawn request releases the grant like a completion.
                if (!g_req || (done && !g_atomic)) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = next_ptr;
                end else if (done) begin
                    state_d = ST_LOCK;
                end
            end
            ST_LOCK: begin
                // While atomic is held the grant sticks, even between transfers.
                if (!g_atomic && (!g_req || done)) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = next_ptr;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        mem_addr   = c_addr[int'(rr_ptr_q)*ADDR_W +: ADDR_W];
        mem_data_w = c_data_w[int'(rr_ptr_q)*DATA_W +: DATA_W];
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_atomic = 1'b0;
        c_wait     = req;
        if (state_q != ST_IDLE) begin
            mem_addr       = c_addr[int'(gnt_q)*ADDR_W +: ADDR_W];
            mem_data_w     = c_data_w[int'(gnt_q)*DATA_W +: DATA_W];
            mem_read       = c_read[gnt_q];
            mem_write      = c_write[gnt_q];
            mem_atomic     = c_atomic[gnt_q];
            c_wait[gnt_q]  = g_req & mem_wait;
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one RAM port between N_PORTS per-core caches in the multicore processor.
- Sits between the caches' ram_* side and the main memory / memory controller.
- Round-robin arbitration; a lock mode keeps the grant on one port across an atomic (read-modify-write) sequence.
- Passes the cache handshake through unchanged: a request is held until the port's wait is low on a clock edge.

Parameters:
- N_PORTS, 4, number of cache ports (2..8).
- IDX_W, 2, width of the grant index; must equal clog2(N_PORTS).

Ports:
- clk  in  1  system clock, rising edge.
- clr_n  in  1  synchronous active-low reset.
- c_addr  in  32*N_PORTS  per-port address; port i occupies bits [32i+31:32i].
- c_data_w  in  32*N_PORTS  per-port write data, same packing as c_addr.
- c_read  in  N_PORTS  per-port read request.
- c_write  in  N_PORTS  per-port write request.
- c_atomic  in  N_PORTS  per-port atomic/lock request.
- c_wait  out  N_PORTS  per-port stall.
- c_data_r  out  32  read data, broadcast to all ports (equals mem_data_r).
- mem_addr  out  32  address to memory.
- mem_data_w  out  32  write data to memory.
- mem_read  out  1  read strobe to memory.
- mem_write  out  1  write strobe to memory.
- mem_atomic  out  1  forwards c_atomic of the granted port.
- mem_wait  in  1  memory stall.
- mem_data_r  in  32  memory read data.
- gnt  out  IDX_W  current grant index (debug/visibility).

Behaviour:
- req[i] = c_read[i] | c_write[i].
- State register has three states: IDLE, GRANT, LOCK.
- Registered: state, gnt, rr_ptr.
- Reset: clr_n low at a rising edge sets state=IDLE, gnt=0, rr_ptr=0.
  - Takes effect at that edge, including mid-transfer; the in-flight transfer is abandoned.
  - After that edge: mem_read=0, mem_write=0, mem_atomic=0, c_wait = req.
- IDLE:
  - mem_read/mem_write/mem_atomic = 0.
  - mem_addr/mem_data_w driven from port rr_ptr (don't-care).
  - c_wait[i] = req[i].
  - If any req: gnt <= first requesting index searching rr_ptr, rr_ptr+1, ..., wrapping modulo N_PORTS; state <= GRANT.
  - Minimum arbitration latency is 1 cycle.
- GRANT and LOCK (g = gnt):
  - mem_addr = c_addr[g], mem_data_w = c_data_w[g].
  - mem_read = c_read[g], mem_write = c_write[g], mem_atomic = c_atomic[g]. All are combinational pass-through.
  - c_wait[g] = req[g] & mem_wait.
  - c_wait[i≠g] = req[i].
  - Completion: req[g] & ~mem_wait at a rising edge.
- GRANT transitions:
  - On completion with c_atomic[g]=1: state <= LOCK.
  - On completion with c_atomic[g]=0: state <= IDLE, rr_ptr <= (g+1) mod N_PORTS.
  - If req[g]=0 (request withdrawn, a protocol violation): state <= IDLE, rr_ptr <= (g+1) mod N_PORTS.
- LOCK:
  - Grant is held; further transfers from g pass through with zero arbitration latency.
  - On completion with c_atomic[g]=1: stay in LOCK.
  - c_atomic[g]=0 and req[g]=0: state <= IDLE, rr_ptr <= g+1 mod N_PORTS.
  - c_atomic[g]=0 and req[g]=1: behave as GRANT (finish the transfer, then release).
  - No timeout; other ports starve while the lock is held, by design.
- Simultaneous requests: round-robin guarantees each requester is served within N_PORTS grants (excluding LOCK time).
- c_read&c_write both high on one port: forwarded as-is; this is a protocol error and is not checked.
- c_data_r = mem_data_r always; a port samples it only on its own completion edge.
- Throughput: 1 bubble cycle (IDLE) between non-locked grants.

Decomposition:
- Shared package/header (mem_bus_defs.vh):
  - State encodings ST_IDLE=2'd0, ST_GRANT=2'd1, ST_LOCK=2'd2.
  - Bus width constant ADDR_W=32, DATA_W=32.
- One sub-module, rr_pick:
  - Combinational priority search from rr_ptr over a req vector.
  - Outputs index plus found flag.
  - Reusable by the later interrupt/IO arbiter.

Test Plan:
- Single request: clr_n released, port 1 writes addr 39 data 1115 with mem_wait=1 for 2 cycles.
  - Grant appears 1 cycle after the request; mem_addr=39, mem_data_w=1115, mem_write=1.
  - c_wait[1]=1 until mem_wait=0; completes; returns to IDLE; rr_ptr=2.
- Contention: ports 0, 2, 3 read simultaneously (addrs 40, 70, 72), rr_ptr=2, mem_wait=0.
  - Grant order 2, 3, 0; each completes in 1 cycle with an IDLE bubble between.
  - Non-granted ports hold c_wait=1.
- Atomic lock: port 3 reads addr 67 with c_atomic=1, then writes 7777, while port 0 requests throughout.
  - Both port-3 transfers are served back-to-back in LOCK; mem_atomic=1.
  - Port 0 is granted only after c_atomic[3] drops.
- Wrap-around: rr_ptr=3, ports 0 and 3 request. Port 3 granted first; rr_ptr wraps to 0; port 0 granted next.
- Reset mid-transfer: clr_n low while port 1 is granted and mem_wait=1.
  - After that edge: mem_read=mem_write=0, state IDLE, gnt=0, rr_ptr=0.
  - With requests still high, the next grant follows the search from rr_ptr=0.
- Withdrawn request: port 2 granted, c_read[2] drops while mem_wait=1.
  - Arbiter returns to IDLE next edge with no completion; rr_ptr=3.
